// File: rtl/multi_debouncer.sv
// multi_debouncer: bank of independent debouncers, one four-state FSM and
// tick counter per channel, with registered one-cycle rise/fall pulses.
//
// Parameters:
//   CHANNELS     - number of independent input channels (>=1)
//   BOUNCE_TICKS - cycles an input must be observed before a change is accepted (>=1)
//   MODE         - 0: sample-at-end, the level at the final tick decides
//                  1: strict-stable, any reversion during the wait aborts it
//
// Ports:
//   clk           - system clock, all logic on posedge
//   rst           - synchronous, active-high reset
//   bouncy_in     - raw per-channel inputs, may glitch
//   debounced_out - filtered level per channel
//   rise_pulse    - one-cycle pulse on the first cycle debounced_out is 1
//   fall_pulse    - one-cycle pulse on the first cycle debounced_out is 0
//
// Optional feature macro: MULTI_DEBOUNCER_SYNC_EN
//   When defined, each bouncy_in bit passes through a 2-flop synchronizer
//   (reset to 0) before the FSM, adding exactly 2 cycles to every latency.
module multi_debouncer #(
    parameter int CHANNELS     = 4,
    parameter int BOUNCE_TICKS = 10,
    parameter int MODE         = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] bouncy_in,
    output logic [CHANNELS-1:0] debounced_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    localparam int unsigned CW = $clog2(BOUNCE_TICKS) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BOUNCE_TICKS - 1);

    // Bit 1 of the encoding is the debounced level.
    localparam logic [1:0] S_0       = 2'b00;
    localparam logic [1:0] S_MAYBE_1 = 2'b01;
    localparam logic [1:0] S_1       = 2'b10;
    localparam logic [1:0] S_MAYBE_0 = 2'b11;

    logic [CHANNELS-1:0] fsm_in;

`ifdef MULTI_DEBOUNCER_SYNC_EN
    // Two-flop synchronizer in front of every channel.
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bouncy_in;
            sync2_q <= sync1_q;
        end
    end

    assign fsm_in = sync2_q;
`else
    assign fsm_in = bouncy_in;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [1:0]    state_q;
        logic [1:0]    state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          rise_q;
        logic          rise_d;
        logic          fall_q;
        logic          fall_d;

        // State, counter and pulse registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= S_0;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // Next-state logic; pulses are derived from the level about to be
        // registered so they line up with the first cycle of the new level.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;

            case (state_q)
                S_0: begin
                    if (fsm_in[g]) begin
                        state_d = S_MAYBE_1;
                        cnt_d   = '0;
                    end
                end
                S_MAYBE_1: begin
                    cnt_d = cnt_q + CW'(1);
                    if ((MODE == 1) && !fsm_in[g]) begin
                        state_d = S_0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = fsm_in[g] ? S_1 : S_0;
                    end
                end
                S_1: begin
                    if (!fsm_in[g]) begin
                        state_d = S_MAYBE_0;
                        cnt_d   = '0;
                    end
                end
                S_MAYBE_0: begin
                    cnt_d = cnt_q + CW'(1);
                    if ((MODE == 1) && fsm_in[g]) begin
                        state_d = S_1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = fsm_in[g] ? S_1 : S_0;
                    end
                end
                default: begin
                    state_d = S_0;
                end
            endcase

            rise_d = !state_q[1] && state_d[1];
            fall_d = state_q[1] && !state_d[1];
        end

        assign debounced_out[g] = state_q[1];
        assign rise_pulse[g]    = rise_q;
        assign fall_pulse[g]    = fall_q;
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Testbench for multi_debouncer: three instances (BOUNCE_TICKS=4 MODE=0,
// BOUNCE_TICKS=4 MODE=1, BOUNCE_TICKS=1 MODE=0) driven with the same inputs,
// checked against a table, hand-written sequences and a behavioural model.
module tb_multi_debouncer;

`ifdef MULTI_DEBOUNCER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    localparam int ND = 3;
    localparam int NC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bouncy_in = 4'h0;
    logic [3:0] dout_w [ND];
    logic [3:0] rise_w [ND];
    logic [3:0] fall_w [ND];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_debouncer #(.CHANNELS(4), .BOUNCE_TICKS(4), .MODE(0)) u_d0 (
        .clk(clk), .rst(rst), .bouncy_in(bouncy_in),
        .debounced_out(dout_w[0]), .rise_pulse(rise_w[0]), .fall_pulse(fall_w[0]));
    multi_debouncer #(.CHANNELS(4), .BOUNCE_TICKS(4), .MODE(1)) u_d1 (
        .clk(clk), .rst(rst), .bouncy_in(bouncy_in),
        .debounced_out(dout_w[1]), .rise_pulse(rise_w[1]), .fall_pulse(fall_w[1]));
    multi_debouncer #(.CHANNELS(4), .BOUNCE_TICKS(1), .MODE(0)) u_d2 (
        .clk(clk), .rst(rst), .bouncy_in(bouncy_in),
        .debounced_out(dout_w[2]), .rise_pulse(rise_w[2]), .fall_pulse(fall_w[2]));

    // Behavioural model: per channel, the accepted level plus an optional
    // pending change with the number of edges elapsed since it began.
    int         cfg_bt [ND] = '{4, 4, 1};
    int         cfg_md [ND] = '{0, 1, 0};
    bit         m_dout [ND][NC];
    bit         m_pend [ND][NC];
    int         m_n    [ND][NC];
    logic [3:0] m_rise [ND];
    logic [3:0] m_fall [ND];
`ifdef MULTI_DEBOUNCER_SYNC_EN
    logic [3:0] s1 = 4'h0;
    logic [3:0] s2 = 4'h0;
`endif

    task automatic model_edge(input bit r, input logic [3:0] x_raw);
        logic [3:0] x;
`ifdef MULTI_DEBOUNCER_SYNC_EN
        x = s2;
        if (r) begin
            s1 = 4'h0;
            s2 = 4'h0;
        end else begin
            s2 = s1;
            s1 = x_raw;
        end
`else
        x = x_raw;
`endif
        for (int d = 0; d < ND; d++) begin
            m_rise[d] = 4'h0;
            m_fall[d] = 4'h0;
            for (int c = 0; c < NC; c++) begin
                if (r) begin
                    m_dout[d][c] = 1'b0;
                    m_pend[d][c] = 1'b0;
                end else if (!m_pend[d][c]) begin
                    if (x[c] != m_dout[d][c]) begin
                        m_pend[d][c] = 1'b1;
                        m_n[d][c]    = 0;
                    end
                end else begin
                    m_n[d][c] = m_n[d][c] + 1;
                    if (cfg_md[d] == 1 && x[c] == m_dout[d][c]) begin
                        m_pend[d][c] = 1'b0;
                    end else if (m_n[d][c] == cfg_bt[d]) begin
                        if (x[c] != m_dout[d][c]) begin
                            m_dout[d][c] = ~m_dout[d][c];
                            if (m_dout[d][c]) m_rise[d][c] = 1'b1;
                            else              m_fall[d][c] = 1'b1;
                        end
                        m_pend[d][c] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] md;
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < NC; c++) md[c] = m_dout[d][c];
            chk($sformatf("dut%0d.debounced_out", d), dout_w[d], md);
            chk($sformatf("dut%0d.rise_pulse", d), rise_w[d], m_rise[d]);
            chk($sformatf("dut%0d.fall_pulse", d), fall_w[d], m_fall[d]);
            chk($sformatf("dut%0d.rise_and_fall", d), rise_w[d] & fall_w[d], 4'h0);
        end
    endtask

    // Drive on the falling edge, model the rising edge, sample 1 ns later.
    task automatic step(input bit r, input logic [3:0] x);
        @(negedge clk);
        rst       = r;
        bouncy_in = x;
        @(posedge clk);
        model_edge(r, x);
        #1;
        check_all();
    endtask

    typedef struct {
        bit         r;
        logic [3:0] in;
        logic [3:0] d;
        logic [3:0] rp;
        logic [3:0] fp;
    } vec_t;

    vec_t tab [20];

    initial begin : main
        logic [3:0] acc_pulse;
        logic [3:0] cur;
        int         r0_at;
        int         r1_at;
        bit         pat [10];

        // Expected values for the BOUNCE_TICKS=4, MODE=0 instance.
        tab[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0};
        tab[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0};
        tab[2]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0};
        tab[3]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0};
        tab[4]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0};
        tab[5]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0};
        tab[6]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0};
        tab[7]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h0};
        tab[8]  = '{1'b0, 4'hE, 4'hF, 4'h0, 4'h0};
        tab[9]  = '{1'b0, 4'hE, 4'hF, 4'h0, 4'h0};
        tab[10] = '{1'b0, 4'hE, 4'hF, 4'h0, 4'h0};
        tab[11] = '{1'b0, 4'hE, 4'hF, 4'h0, 4'h0};
        tab[12] = '{1'b0, 4'hE, 4'hE, 4'h0, 4'h1};
        tab[13] = '{1'b0, 4'hE, 4'hE, 4'h0, 4'h0};
        tab[14] = '{1'b0, 4'h7, 4'hE, 4'h0, 4'h0};
        tab[15] = '{1'b0, 4'h7, 4'hE, 4'h0, 4'h0};
        tab[16] = '{1'b0, 4'h7, 4'hE, 4'h0, 4'h0};
        tab[17] = '{1'b0, 4'h7, 4'hE, 4'h0, 4'h0};
        tab[18] = '{1'b0, 4'h7, 4'h7, 4'h1, 4'h8};
        tab[19] = '{1'b0, 4'h7, 4'h7, 4'h0, 4'h0};

        for (int d = 0; d < ND; d++) begin
            m_rise[d] = 4'h0;
            m_fall[d] = 4'h0;
            for (int c = 0; c < NC; c++) begin
                m_dout[d][c] = 1'b0;
                m_pend[d][c] = 1'b0;
                m_n[d][c]    = 0;
            end
        end

        // Table: reset, press all, release ch0, simultaneous ch0 press / ch3 release.
        for (int i = 0; i < 20; i++) begin
            vec_t e;
            int   k;
            step(tab[i].r, tab[i].in);
            k = i - SYNC_LAT;
            e = (k >= 0) ? tab[k] : '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
            chk($sformatf("table[%0d].debounced_out", i), dout_w[0], e.d);
            chk($sformatf("table[%0d].rise_pulse", i), rise_w[0], e.rp);
            chk($sformatf("table[%0d].fall_pulse", i), fall_w[0], e.fp);
        end

        // Single-cycle glitch on ch1 must be rejected by every BOUNCE_TICKS=4 instance.
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        acc_pulse = 4'h0;
        step(1'b0, 4'h2);
        acc_pulse |= rise_w[0] | fall_w[0] | rise_w[1] | fall_w[1];
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'h0);
            acc_pulse |= rise_w[0] | fall_w[0] | rise_w[1] | fall_w[1];
        end
        chk("glitch.no_pulse", acc_pulse, 4'h0);
        chk("glitch.mode0_level", dout_w[0], 4'h0);

        // ch1 pattern 1,1,0,1,1,...: MODE=1 restarts after the 0, MODE=0 does not.
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        r0_at = -1;
        r1_at = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, {2'b00, pat[i], 1'b0});
            if (rise_w[0][1] && r0_at < 0) r0_at = i;
            if (rise_w[1][1] && r1_at < 0) r1_at = i;
        end
        chk_int("mode0.rise_edge", r0_at, 4 + SYNC_LAT);
        chk_int("mode1.rise_edge", r1_at, 7 + SYNC_LAT);

        // Reset during a pending rise on ch0: no pulse, level stays low.
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        step(1'b0, 4'h1);
        step(1'b0, 4'h1);
        step(1'b0, 4'h1);
        step(1'b1, 4'h1);
        acc_pulse = 4'h0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'h0);
            acc_pulse |= rise_w[0] | rise_w[1] | rise_w[2];
        end
        chk("midreset.no_pulse", acc_pulse, 4'h0);
        chk("midreset.level", dout_w[0], 4'h0);

        // Randomised bouncing inputs with occasional resets, model-checked.
        cur = 4'h0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 4) == 0) cur[c] = ~cur[c];
            end
            step(($urandom_range(0, 79) == 0), cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
